// File: rtl/ps2_digit_entry.sv
// PS/2 keyboard digit-entry controller: filtered PS/2 receiver, set-2 decoder,
// and a BCD entry buffer with backspace/escape/enter editing.
module ps2_digit_entry #(
  parameter int NUM_DIGITS  = 3,
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    PS2_CLK,
  input  logic                    PS2_DATA,
  output logic [4*NUM_DIGITS-1:0] oNum,
  output logic [3:0]              oDigitCnt,
  output logic                    oNumRdy,
  output logic [2:0]              oLED
);
  localparam int NW = 4*NUM_DIGITS;
  localparam int FW = $clog2(FILT_LEN+1);
  localparam int TW = $clog2(TIMEOUT_CYC+1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;
  typedef enum logic [2:0] {A_NONE, A_DIGIT, A_BS, A_ENTER, A_ESC} act_t;

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_filt, clk_filt_d, fall, din;
  logic [FW-1:0] filt_cnt;

  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg, code;
  logic          par, code_vld, frame_err;
  logic [TW-1:0] tcnt;

  logic          brk, ext, committed, ovf, ferr;
  act_t          act;
  logic [3:0]    dig;
  logic [4:0]    main_d, kp_d;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DATA};
    end
  end

  // Filtered clock flips only after FILT_LEN consecutive samples disagree with it.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_sync[1] == clk_filt) filt_cnt <= '0;
      else if (filt_cnt == FW'(FILT_LEN-1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
      end else filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign fall = clk_filt_d & ~clk_filt;
  assign din  = dat_sync[1];

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      code      <= '0;
      code_vld  <= 1'b0;
      frame_err <= 1'b0;
      tcnt      <= '0;
    end else begin
      code_vld  <= 1'b0;
      frame_err <= 1'b0;
      if (fall || state == S_IDLE) tcnt <= '0;
      else                         tcnt <= tcnt + 1'b1;
      case (state)
        S_IDLE:   if (fall && !din) begin
                    state   <= S_DATA;
                    bit_cnt <= '0;
                  end
        S_DATA:   if (fall) begin
                    shreg   <= {din, shreg[7:1]};
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) state <= S_PARITY;
                  end
        S_PARITY: if (fall) begin
                    par   <= din;
                    state <= S_STOP;
                  end
        S_STOP:   if (fall) begin
                    if (din && (^{shreg, par})) begin
                      code_vld <= 1'b1;
                      code     <= shreg;
                    end else frame_err <= 1'b1;
                    state <= S_IDLE;
                  end
        default:  state <= S_IDLE;
      endcase
      // A stalled partial frame is abandoned and reported as a frame error.
      if (state != S_IDLE && !fall && tcnt == TW'(TIMEOUT_CYC-1)) begin
        state     <= S_IDLE;
        frame_err <= 1'b1;
        tcnt      <= '0;
      end
    end
  end

  function automatic logic [4:0] main_digit(input logic [7:0] c);
    case (c)
      8'h45: return {1'b1, 4'd0};  8'h16: return {1'b1, 4'd1};
      8'h1E: return {1'b1, 4'd2};  8'h26: return {1'b1, 4'd3};
      8'h25: return {1'b1, 4'd4};  8'h2E: return {1'b1, 4'd5};
      8'h36: return {1'b1, 4'd6};  8'h3D: return {1'b1, 4'd7};
      8'h3E: return {1'b1, 4'd8};  8'h46: return {1'b1, 4'd9};
      default: return 5'd0;
    endcase
  endfunction

  function automatic logic [4:0] kp_digit(input logic [7:0] c);
    case (c)
      8'h70: return {1'b1, 4'd0};  8'h69: return {1'b1, 4'd1};
      8'h72: return {1'b1, 4'd2};  8'h7A: return {1'b1, 4'd3};
      8'h6B: return {1'b1, 4'd4};  8'h73: return {1'b1, 4'd5};
      8'h74: return {1'b1, 4'd6};  8'h6C: return {1'b1, 4'd7};
      8'h75: return {1'b1, 4'd8};  8'h7D: return {1'b1, 4'd9};
      default: return 5'd0;
    endcase
  endfunction

  assign main_d = main_digit(code);
  assign kp_d   = kp_digit(code);

  always_comb begin
    act = A_NONE;
    dig = 4'd0;
    if (code_vld && !brk && code != 8'hF0 && code != 8'hE0) begin
      if (ext) begin
        if (code == 8'h5A) act = A_ENTER;
      end else if (main_d[4]) begin
        act = A_DIGIT;
        dig = main_d[3:0];
      end else if (kp_d[4]) begin
        act = A_DIGIT;
        dig = kp_d[3:0];
      end else begin
        case (code)
          8'h66:   act = A_BS;
          8'h5A:   act = A_ENTER;
          8'h76:   act = A_ESC;
          default: act = A_NONE;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      brk <= 1'b0;
      ext <= 1'b0;
    end else if (code_vld) begin
      if (brk) begin
        brk <= 1'b0;
        ext <= 1'b0;
      end else if (code == 8'hF0) brk <= 1'b1;
      else if (code == 8'hE0)     ext <= 1'b1;
      else                        ext <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      oNum      <= '0;
      oDigitCnt <= '0;
      oNumRdy   <= 1'b0;
      committed <= 1'b0;
      ovf       <= 1'b0;
      ferr      <= 1'b0;
    end else begin
      oNumRdy <= 1'b0;
      case (act)
        A_DIGIT: if (committed) begin
                   oNum      <= NW'(dig);
                   oDigitCnt <= 4'd1;
                   committed <= 1'b0;
                 end else if (oDigitCnt == 4'(NUM_DIGITS)) ovf <= 1'b1;
                 else begin
                   oNum      <= NW'({oNum, dig});
                   oDigitCnt <= oDigitCnt + 1'b1;
                 end
        A_BS:    begin
                   if (oDigitCnt != 4'd0) begin
                     oNum      <= oNum >> 4;
                     oDigitCnt <= oDigitCnt - 1'b1;
                   end
                   ovf <= 1'b0;
                 end
        A_ENTER: if (oDigitCnt != 4'd0) begin
                   oNumRdy   <= 1'b1;
                   committed <= 1'b1;
                   ovf       <= 1'b0;
                   ferr      <= 1'b0;
                 end
        A_ESC:   begin
                   oNum      <= '0;
                   oDigitCnt <= '0;
                   committed <= 1'b0;
                   ovf       <= 1'b0;
                   ferr      <= 1'b0;
                 end
        default: ;
      endcase
      if (frame_err) ferr <= 1'b1;
    end
  end

  assign oLED = {(oDigitCnt != 4'd0) && !committed, ovf, ferr};
endmodule
